poly_mod_to_bin: RTL and testbench

POLY_MOD_TO_BIN -- requirements
Module: poly_mod_to_bin

---
 rtl/poly_mod_to_bin.sv | 122 ++++++++++++
 tb/tb_poly_mod_to_bin.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_mod_to_bin.sv
// poly_mod_to_bin: converts a redundant-form polynomial (coefficients wider
// than the radix) into a plain binary integer by rippling the carry one word
// per cycle, least significant word first.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high on the same side (i_val/o_rdy upstream, o_val/i_rdy downstream).
// Valid must not depend on ready. o_dat is held stable while o_val=1 and
// i_rdy=0. In DONE, an upstream accept and a downstream handshake may share
// the same edge, which gives back-to-back operation with no idle bubble.
module poly_mod_to_bin #(
    parameter int WORD_BITS       = 8,
    parameter int NUM_WORDS       = 4,
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD          = NUM_WORDS + 1,
    parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
    parameter int O_BITS          = (I_WORD - 1) * WORD_BITS + COEF_BITS + 1
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_val,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]    i_dat,
    output logic                                o_rdy,
    output logic                                o_val,
    output logic [O_BITS-1:0]                   o_dat,
    input  logic                                i_rdy,
    output logic [1:0]                          o_dbg_state
);

    // Carry never exceeds this width: an all-ones coefficient plus the
    // largest carry still fits in COEF_BITS+1 bits.
    localparam int CARRY_BITS = COEF_BITS + 1 - WORD_BITS;
    localparam int IDX_W      = (I_WORD > 1) ? $clog2(I_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(I_WORD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROP = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                             state_q;
    logic                               val_q;
    logic [I_WORD-1:0][COEF_BITS-1:0]   coef_q;
    logic [CARRY_BITS-1:0]              carry_q;
    logic [IDX_W-1:0]                   idx_q;
    // Low result words are exactly WORD_BITS wide; the top word keeps the
    // full sum so no bits of the final carry are dropped.
    logic [I_WORD-2:0][WORD_BITS-1:0]   lo_q;
    logic [COEF_BITS:0]                 hi_q;

    logic [COEF_BITS-1:0]               coef_sel;
    logic [COEF_BITS:0]                 sum_d;
    logic [CARRY_BITS-1:0]              carry_d;
    logic                               accept;

    assign o_rdy       = (state_q == IDLE) || ((state_q == DONE) && i_rdy);
    assign accept      = i_val && o_rdy;
    assign o_val       = val_q;
    assign o_dat       = {hi_q, lo_q};
    assign o_dbg_state = state_q;

    // Select the current coefficient and add the running carry.
    always_comb begin
        coef_sel = '0;
        for (int k = 0; k < I_WORD; k++) begin
            if (idx_q == IDX_W'(k)) begin
                coef_sel = coef_q[k];
            end
        end
        sum_d   = {1'b0, coef_sel} + {{WORD_BITS{1'b0}}, carry_q};
        carry_d = sum_d[COEF_BITS:WORD_BITS];
    end

    // Control FSM plus datapath registers; accept takes priority so a DONE
    // handshake can restart the conversion on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            val_q   <= 1'b0;
            coef_q  <= '0;
            carry_q <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else if (accept) begin
            state_q <= PROP;
            val_q   <= 1'b0;
            coef_q  <= i_dat;
            carry_q <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                PROP: begin
                    if (idx_q == LAST_IDX) begin
                        hi_q    <= sum_d;
                        state_q <= DONE;
                        val_q   <= 1'b1;
                    end else begin
                        for (int k = 0; k < I_WORD - 1; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                lo_q[k] <= sum_d[WORD_BITS-1:0];
                            end
                        end
                        carry_q <= carry_d;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        state_q <= IDLE;
                        val_q   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_mod_to_bin.sv
// tb_poly_mod_to_bin: directed tests for the redundant-to-binary converter
// at default parameters, with hand-computed expected results.
module tb_poly_mod_to_bin;

    localparam int WORD_BITS = 8;
    localparam int I_WORD    = 5;
    localparam int COEF_BITS = 9;
    localparam int O_BITS    = 42;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROP = 2'd1;

    logic                               i_clk;
    logic                               i_rst_n;
    logic                               i_val;
    logic [I_WORD-1:0][COEF_BITS-1:0]   i_dat;
    logic                               o_rdy;
    logic                               o_val;
    logic [O_BITS-1:0]                  o_dat;
    logic                               i_rdy;
    logic [1:0]                         o_dbg_state;

    int errors = 0;
    int checks = 0;

    poly_mod_to_bin dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_val       (i_val),
        .i_dat       (i_dat),
        .o_rdy       (o_rdy),
        .o_val       (o_val),
        .o_dat       (o_dat),
        .i_rdy       (i_rdy),
        .o_dbg_state (o_dbg_state)
    );

    // Clock: 10 ns period.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present d for one accept edge, then count edges until o_val rises.
    task automatic accept_and_wait(input logic [I_WORD-1:0][COEF_BITS-1:0] d, output int n);
        i_dat = d;
        i_val = 1'b1;
        tick();
        i_val = 1'b0;
        n = 0;
        while (o_val !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_val   = 1'b0;
        i_rdy   = 1'b1;
        i_dat   = '0;
        #12;
        checks++;
        if (o_val !== 1'b0) begin
            errors++; $display("FAIL reset_o_val got=%b exp=0", o_val);
        end
        checks++;
        if (o_dat !== '0) begin
            errors++; $display("FAIL reset_o_dat got=%h exp=0", o_dat);
        end
        checks++;
        if (o_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_o_rdy got=%b exp=1", o_rdy);
        end
        checks++;
        if (o_dbg_state !== S_IDLE) begin
            errors++; $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, S_IDLE);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [I_WORD-1:0][COEF_BITS-1:0] d;
        int n;
        d = '0;
        d[0] = 9'h100;
        i_rdy = 1'b1;
        i_dat = d;
        i_val = 1'b1;
        tick();
        i_val = 1'b0;
        checks++;
        if (o_rdy !== 1'b0) begin
            errors++; $display("FAIL single_prop_rdy got=%b exp=0", o_rdy);
        end
        n = 0;
        while (o_val !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL single_latency got=%0d exp=5", n);
        end
        checks++;
        if (o_dat !== 42'h100) begin
            errors++; $display("FAIL single_o_dat got=%h exp=%h", o_dat, 42'h100);
        end
        checks++;
        if (o_rdy !== 1'b1) begin
            errors++; $display("FAIL single_done_rdy got=%b exp=1", o_rdy);
        end
        tick();
        checks++;
        if (o_val !== 1'b0 || o_dbg_state !== S_IDLE) begin
            errors++; $display("FAIL single_to_idle got val=%b st=%0d exp val=0 st=0", o_val, o_dbg_state);
        end
    endtask

    task automatic test_ripple();
        logic [I_WORD-1:0][COEF_BITS-1:0] d;
        int n;
        i_rdy = 1'b1;
        for (int k = 0; k < I_WORD; k++) d[k] = 9'h1FF;
        accept_and_wait(d, n);
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL ripple_latency got=%0d exp=5", n);
        end
        checks++;
        if (o_dat !== 42'h0201010100FF) begin
            errors++; $display("FAIL ripple_all_ones got=%h exp=%h", o_dat, 42'h0201010100FF);
        end
        tick();
        d[0] = 9'h080; d[1] = 9'h1FF; d[2] = 9'h055; d[3] = 9'h1C3; d[4] = 9'h0AB;
        accept_and_wait(d, n);
        checks++;
        if (o_dat !== 42'hACC356FF80) begin
            errors++; $display("FAIL ripple_mixed got=%h exp=%h", o_dat, 42'hACC356FF80);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [I_WORD-1:0][COEF_BITS-1:0] d;
        int n;
        int bad;
        d = '0;
        d[4] = 9'h1FF;
        i_rdy = 1'b0;
        accept_and_wait(d, n);
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL stall_latency got=%0d exp=5", n);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (o_val !== 1'b1 || o_rdy !== 1'b0 || o_dat !== 42'h1FF00000000) begin
                errors++; bad++;
                if (bad < 3) $display("FAIL stall_hold cyc=%0d got val=%b rdy=%b dat=%h exp val=1 rdy=0 dat=%h",
                                      c, o_val, o_rdy, o_dat, 42'h1FF00000000);
            end
            tick();
        end
        i_rdy = 1'b1;
        tick();
        checks++;
        if (o_val !== 1'b0) begin
            errors++; $display("FAIL stall_release got=%b exp=0", o_val);
        end
    endtask

    task automatic test_back_to_back();
        logic [I_WORD-1:0][COEF_BITS-1:0] a;
        logic [I_WORD-1:0][COEF_BITS-1:0] b;
        logic [I_WORD-1:0][COEF_BITS-1:0] junk;
        int n;
        a = '0; a[0] = 9'h1FF;
        b = '0; b[2] = 9'h123;
        for (int k = 0; k < I_WORD; k++) junk[k] = 9'h1AA;
        i_rdy = 1'b1;
        i_dat = a;
        i_val = 1'b1;
        tick();
        // Junk presented while converting must be ignored.
        i_dat = junk;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) i_val = 1'b0;
            tick();
        end
        checks++;
        if (o_val !== 1'b0) begin
            errors++; $display("FAIL b2b_prop_ignore got=%b exp=0", o_val);
        end
        tick();
        checks++;
        if (o_val !== 1'b1 || o_dat !== 42'h1FF) begin
            errors++; $display("FAIL b2b_first got val=%b dat=%h exp val=1 dat=%h", o_val, o_dat, 42'h1FF);
        end
        i_dat = b;
        i_val = 1'b1;
        tick();
        i_val = 1'b0;
        checks++;
        if (o_val !== 1'b0 || o_dbg_state !== S_PROP) begin
            errors++; $display("FAIL b2b_no_bubble got val=%b st=%0d exp val=0 st=1", o_val, o_dbg_state);
        end
        n = 0;
        while (o_val !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL b2b_latency got=%0d exp=5", n);
        end
        checks++;
        if (o_dat !== 42'h1230000) begin
            errors++; $display("FAIL b2b_second got=%h exp=%h", o_dat, 42'h1230000);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [I_WORD-1:0][COEF_BITS-1:0] d;
        int n;
        int pulses;
        for (int k = 0; k < I_WORD; k++) d[k] = 9'h1FF;
        i_rdy = 1'b1;
        i_dat = d;
        i_val = 1'b1;
        tick();
        i_val = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_val !== 1'b0 || o_dat !== '0 || o_rdy !== 1'b1) begin
            errors++; $display("FAIL midreset_async got val=%b dat=%h rdy=%b exp val=0 dat=0 rdy=1",
                               o_val, o_dat, o_rdy);
        end
        tick();
        tick();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_val !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midreset_no_pulse got=%0d exp=0", pulses);
        end
        d = '0;
        d[0] = 9'h1FF;
        accept_and_wait(d, n);
        checks++;
        if (n !== 5 || o_dat !== 42'h1FF) begin
            errors++; $display("FAIL midreset_fresh got n=%0d dat=%h exp n=5 dat=%h", n, o_dat, 42'h1FF);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ripple();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
